// File: rtl/div_pkg.sv
// Shared definitions for the programmable clock-enable divider:
// FSM state encodings and the divider mode constants.
package div_pkg;

    typedef enum logic [1:0] {
        FREE = 2'd0,
        IDLE = 2'd1,
        RUN  = 2'd2
    } state_t;

    localparam logic MODE_PERIODIC = 1'b0;
    localparam logic MODE_ONESHOT  = 1'b1;

endpackage

// File: rtl/div_n_if.sv
// Control/status bundle of the divider: load and start strobes in,
// registered terminal-count pulse, count and status out.
interface div_n_if #(
    parameter int WIDTH = 16
);

    logic             en;
    logic             div_load;
    logic [WIDTH-1:0] div_value;
    logic             mode;
    logic             start;
    logic             cycle;
    logic [WIDTH-1:0] count;
    logic             busy;
    logic             div_err;

    modport master (
        output en, div_load, div_value, mode, start,
        input  cycle, count, busy, div_err
    );

    modport slave (
        input  en, div_load, div_value, mode, start,
        output cycle, count, busy, div_err
    );

endinterface

// File: rtl/div_core.sv
// WIDTH-bit counter with enable and synchronous clear; wraps to zero when
// it reaches div_reg-1, and flags that terminal value combinationally.
module div_core #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    input  logic [WIDTH-1:0] div_reg,
    output logic [WIDTH-1:0] count,
    output logic             term
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    // The only wrap path is this compare, so count never reaches div_reg.
    assign term = (count == (div_reg - ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= term ? '0 : (count + ONE);
        end
    end

endmodule

// File: rtl/div_n.sv
// Programmable divide-by-N with periodic and one-shot modes; owns the
// FSM, divisor/mode registers and load validation around div_core.
module div_n
    import div_pkg::*;
#(
    parameter int WIDTH       = 16,
    parameter int DEFAULT_DIV = 100
) (
    input logic   clk,
    input logic   rst,
    div_n_if.slave bus
);

    localparam logic [WIDTH-1:0] RESET_DIV = WIDTH'(DEFAULT_DIV);

    state_t           state;
    logic [WIDTH-1:0] div_reg;
    logic             mode_reg;
    logic             load_ok;
    logic             load_bad;
    logic             term;
    logic             clr;
    logic             inc;

    assign load_ok  = bus.div_load && (bus.div_value != '0);
    assign load_bad = bus.div_load && (bus.div_value == '0);

    // IDLE pins the count at zero, which also gives start its count<=0.
    assign clr = load_ok || (state == IDLE);
    assign inc = bus.en && (state != IDLE);

    div_core #(
        .WIDTH (WIDTH)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .inc     (inc),
        .clr     (clr),
        .div_reg (div_reg),
        .count   (bus.count),
        .term    (term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= FREE;
            div_reg     <= RESET_DIV;
            mode_reg    <= MODE_PERIODIC;
            bus.cycle   <= 1'b0;
            bus.busy    <= 1'b0;
            bus.div_err <= 1'b0;
        end else begin
            bus.div_err <= load_bad;
            bus.cycle   <= 1'b0;
            if (load_ok) begin
                // A valid load wins over start and over a coincident terminal count.
                div_reg  <= bus.div_value;
                mode_reg <= bus.mode;
                bus.busy <= 1'b0;
                state    <= (bus.mode == MODE_ONESHOT) ? IDLE : FREE;
            end else begin
                case (state)
                    FREE: begin
                        if (bus.en && term) begin
                            bus.cycle <= 1'b1;
                        end
                    end
                    IDLE: begin
                        if (bus.start) begin
                            bus.busy <= 1'b1;
                            state    <= RUN;
                        end
                    end
                    RUN: begin
                        if (bus.en && term) begin
                            bus.cycle <= 1'b1;
                            bus.busy  <= 1'b0;
                            state     <= (mode_reg == MODE_ONESHOT) ? IDLE : FREE;
                        end
                    end
                    default: begin
                        bus.busy <= 1'b0;
                        state    <= FREE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_div_n.sv
// Self-checking bench for div_n: directed scenarios plus random traffic,
// compared every clock against a behavioural period/run model.
module tb_div_n;

    localparam int WIDTH = 16;
    localparam int DEF   = 100;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    // Behavioural model: divisor, mode, position within period, run flag.
    int   m_n;
    bit   m_oneshot;
    int   m_pos;
    bit   m_running;
    bit   e_cycle;
    bit   e_err;
    int   pulses;
    int   last_pulse;

    div_n_if #(.WIDTH(WIDTH)) bus ();

    div_n #(
        .WIDTH       (WIDTH),
        .DEFAULT_DIV (DEF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int observed, input int expected);
        n_checks++;
        assert (observed === expected) else begin
            n_fail++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
        end
    endtask

    task automatic model_reset();
        m_n       = DEF;
        m_oneshot = 1'b0;
        m_pos     = 0;
        m_running = 1'b0;
        e_cycle   = 1'b0;
        e_err     = 1'b0;
    endtask

    task automatic model_edge(input bit en, input bit ld, input int val,
                              input bit md, input bit st);
        e_err   = ld && (val == 0);
        e_cycle = 1'b0;
        if (ld && val != 0) begin
            m_n       = val;
            m_oneshot = md;
            m_pos     = 0;
            m_running = 1'b0;
        end else if (!m_oneshot || m_running) begin
            if (en) begin
                m_pos = m_pos + 1;
                if (m_pos == m_n) begin
                    m_pos   = 0;
                    e_cycle = 1'b1;
                    if (m_oneshot) m_running = 1'b0;
                end
            end
        end else begin
            m_pos = 0;
            if (st) m_running = 1'b1;
        end
    endtask

    task automatic compare_all(input string tag);
        check({tag, ".cycle"},   int'(bus.cycle),   int'(e_cycle));
        check({tag, ".count"},   int'(bus.count),   m_pos);
        check({tag, ".busy"},    int'(bus.busy),    int'(m_running));
        check({tag, ".div_err"}, int'(bus.div_err), int'(e_err));
    endtask

    // One clock: drive inputs, let the edge happen, update model, compare 1ns later.
    task automatic step(input string tag, input bit en, input bit ld, input int val,
                        input bit md, input bit st);
        bus.en        = en;
        bus.div_load  = ld;
        bus.div_value = WIDTH'(val);
        bus.mode      = md;
        bus.start     = st;
        @(posedge clk);
        model_edge(en, ld, val, md, st);
        #1;
        compare_all(tag);
        bus.div_load = 1'b0;
        bus.start    = 1'b0;
    endtask

    initial begin
        bus.en        = 1'b0;
        bus.div_load  = 1'b0;
        bus.div_value = '0;
        bus.mode      = 1'b0;
        bus.start     = 1'b0;
        model_reset();

        // Reset state
        #12;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        // Default divisor: pulses at enabled edges 100, 200, 300
        pulses = 0;
        last_pulse = 0;
        for (int i = 1; i <= 300; i++) begin
            step("def", 1'b1, 1'b0, 0, 1'b0, 1'b0);
            if (bus.cycle === 1'b1) begin
                pulses++;
                check("def.pulse_edge", i, pulses * 100);
                last_pulse = i;
            end
        end
        check("def.pulse_total", pulses, 3);
        check("def.last_pulse", last_pulse, 300);

        // Rejected zero load at count 40
        for (int i = 0; i < 40; i++) step("pre0", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("zero.at40", int'(bus.count), 40);
        step("zero.load", 1'b1, 1'b1, 0, 1'b1, 1'b0);
        check("zero.count41", int'(bus.count), 41);
        for (int i = 0; i < 70; i++) step("zero.run", 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // Periodic divide-by-5 with a 3-clock enable gap
        step("ld5", 1'b1, 1'b1, 5, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step("p5", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) step("p5.hold", 1'b0, 1'b0, 0, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) step("p5", 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // Divide-by-1, then a valid load on a terminal clock suppresses the pulse
        step("ld1", 1'b1, 1'b1, 1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) step("p1", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        step("p1.loadterm", 1'b1, 1'b1, 3, 1'b0, 1'b0);
        check("p1.nopulse", int'(bus.cycle), 0);
        for (int i = 0; i < 6; i++) step("p3", 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // One-shot of 4, second start ignored, start on terminal clock ignored
        step("ld4os", 1'b1, 1'b1, 4, 1'b1, 1'b0);
        step("os.idle", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        step("os.start", 1'b1, 1'b0, 0, 1'b0, 1'b1);
        step("os.run", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        step("os.restart", 1'b1, 1'b0, 0, 1'b0, 1'b1);
        step("os.run", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        step("os.term", 1'b1, 1'b0, 0, 1'b0, 1'b1);
        check("os.idle_busy", int'(bus.busy), 0);
        for (int i = 0; i < 3; i++) step("os.after", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        step("os.start2", 1'b1, 1'b0, 0, 1'b0, 1'b1);
        for (int i = 0; i < 5; i++) step("os.run2", 1'b1, 1'b0, 0, 1'b0, 1'b0);

        // Random traffic across both modes
        for (int i = 0; i < 600; i++) begin
            automatic bit ld = ($urandom_range(0, 15) == 0);
            step("rand", bit'($urandom_range(0, 3) != 0), ld, int'($urandom_range(0, 7)),
                 bit'($urandom_range(0, 1)), bit'($urandom_range(0, 3) == 0));
        end

        // Asynchronous reset mid-run at count 2
        step("rst.ld", 1'b1, 1'b1, 4, 1'b1, 1'b0);
        step("rst.start", 1'b1, 1'b0, 0, 1'b0, 1'b1);
        step("rst.run", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        step("rst.run", 1'b1, 1'b0, 0, 1'b0, 1'b0);
        check("rst.count2", int'(bus.count), 2);
        rst = 1'b1;
        model_reset();
        #1;
        compare_all("rst.async");
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 205; i++) step("rst.free", 1'b1, 1'b0, 0, 1'b0, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
